// File: rtl/lvda_serial_word_tx_pkg.sv
// rtl/lvda_serial_word_tx_pkg.sv - shared LVDC/LVDA serial link definitions
//
// Purpose: constants and FSM encoding shared between the LVDA serial word
//          transmitter and the LVDC capture logic.
// Contents:
//   LVDC_WORD_W       data bits per frame
//   LVDC_GUARD_SLOTS  strobe edges between frame start and the first sampled bit
//   LVDC_SYNC_STAGES  synchroniser depth for the asynchronous link inputs
//   lvdc_state_e      frame FSM state encoding
//   cnt_w()           width of a down-counter that must hold max_val
package lvda_serial_word_tx_pkg;

  localparam int LVDC_WORD_W      = 26;
  localparam int LVDC_GUARD_SLOTS = 1;
  localparam int LVDC_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } lvdc_state_e;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lvda_sync_edge.sv
// rtl/lvda_sync_edge.sv - multi-flop synchroniser with rising-edge pulse
//
// Purpose: brings an asynchronous level into the i_clk domain and flags its
//          rising edge with a single-cycle pulse.
// Ports:
//   i_clk    in   clock
//   i_rst    in   synchronous reset, active-high; clears every flop
//   i_async  in   asynchronous input level
//   o_level  out  synchronised level (STAGES flops deep)
//   o_rise   out  1-cycle pulse on the first cycle o_level is high
module lvda_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_level_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[STAGES-2:0], i_async};
      r_level_d <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  // Combinational edge so that the consumer acts one cycle after the level
  // settles: total latency from the input rise is STAGES+1 clocks.
  assign o_rise  = r_sync[STAGES-1] & ~r_level_d;

endmodule

// File: rtl/lvda_serial_word_tx.sv
// rtl/lvda_serial_word_tx.sv - LVDA serial word transmitter (DATAV driver)
//
// Purpose: shifts a WORD_W-bit word MSB first onto DATA_OUT, paced by the
//          rising edges of the WDA strobe. A PBV rise sampled on a WDA edge
//          starts a frame; GUARD_SLOTS edges follow before the first bit.
// Ports:
//   SIM_CLK   in   single clock
//   SIM_RST   in   synchronous reset, active-high
//   WDA       in   asynchronous bit strobe
//   PBV       in   asynchronous frame-request level
//   tx_data   in   word to transmit
//   tx_valid  in   tx_data valid
//   tx_ready  out  staging register empty
//   DATA_OUT  out  serial data
//   busy      out  frame in GUARD or SHIFT
//   done      out  1-cycle pulse on the receiver latch edge
//   underrun  out  1-cycle pulse when a frame starts with nothing staged
//   restart   out  1-cycle pulse when a frame start aborts a running frame
module lvda_serial_word_tx
  import lvda_serial_word_tx_pkg::*;
#(
  parameter int WORD_W      = LVDC_WORD_W,
  parameter int GUARD_SLOTS = LVDC_GUARD_SLOTS,
  parameter int SYNC_STAGES = LVDC_SYNC_STAGES
) (
  input  logic              SIM_CLK,
  input  logic              SIM_RST,
  input  logic              WDA,
  input  logic              PBV,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              DATA_OUT,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic              restart
);

  localparam int GCNT_W = cnt_w(GUARD_SLOTS);
  localparam int BCNT_W = cnt_w(WORD_W - 1);

  lvdc_state_e       r_state, w_state_nxt;
  logic [WORD_W-1:0] r_sr, w_sr_nxt;
  logic [WORD_W-1:0] r_stage_data;
  logic              r_staged;
  logic              r_pbv_prev;
  logic [GCNT_W-1:0] r_gcnt, w_gcnt_nxt;
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt;
  logic              r_data_out, w_data_out_nxt;
  logic              r_done, w_done_nxt;
  logic              r_underrun, w_underrun_nxt;
  logic              r_restart, w_restart_nxt;

  logic w_wr;
  logic w_wda_s;
  logic w_pbv_s;
  logic w_pbv_rise_unused;
  logic w_fs;
  logic w_load;

  lvda_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_wda (
    .i_clk   (SIM_CLK),
    .i_rst   (SIM_RST),
    .i_async (WDA),
    .o_level (w_wda_s),
    .o_rise  (w_wr)
  );

  // PBV is only ever looked at on a strobe edge, so its own edge pulse is
  // not needed; the level is compared against r_pbv_prev instead.
  lvda_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pbv (
    .i_clk   (SIM_CLK),
    .i_rst   (SIM_RST),
    .i_async (PBV),
    .o_level (w_pbv_s),
    .o_rise  (w_pbv_rise_unused)
  );

  assign w_fs   = w_wr & w_pbv_s & ~r_pbv_prev;
  assign w_load = tx_valid & ~r_staged;

  // State register
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; a frame start wins over every other transition
  always_comb begin
    w_state_nxt = r_state;
    if (w_fs) begin
      w_state_nxt = ST_GUARD;
    end else if (w_wr) begin
      case (r_state)
        ST_GUARD: if (r_gcnt == GCNT_W'(1)) w_state_nxt = ST_SHIFT;
        ST_SHIFT: if (r_bcnt == '0)         w_state_nxt = ST_LATCH;
        ST_LATCH: w_state_nxt = ST_IDLE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    w_sr_nxt       = r_sr;
    w_gcnt_nxt     = r_gcnt;
    w_bcnt_nxt     = r_bcnt;
    w_data_out_nxt = r_data_out;
    w_done_nxt     = 1'b0;
    w_underrun_nxt = 1'b0;
    w_restart_nxt  = 1'b0;
    if (w_fs) begin
      w_sr_nxt       = r_staged ? r_stage_data : '0;
      w_underrun_nxt = ~r_staged;
      w_restart_nxt  = (r_state != ST_IDLE);
      w_data_out_nxt = 1'b0;
      w_gcnt_nxt     = GCNT_W'(GUARD_SLOTS);
    end else if (w_wr) begin
      case (r_state)
        ST_GUARD: begin
          w_gcnt_nxt = r_gcnt - GCNT_W'(1);
          if (r_gcnt == GCNT_W'(1)) begin
            w_data_out_nxt = r_sr[WORD_W-1];
            w_bcnt_nxt     = BCNT_W'(WORD_W - 1);
          end
        end
        ST_SHIFT: begin
          // This edge is the receiver's sample of the bit on the line.
          if (r_bcnt != '0) begin
            w_sr_nxt       = r_sr << 1;
            w_data_out_nxt = r_sr[WORD_W-2];
            w_bcnt_nxt     = r_bcnt - BCNT_W'(1);
          end else begin
            w_data_out_nxt = 1'b0;
          end
        end
        ST_LATCH: w_done_nxt = 1'b1;
        default:  w_done_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      r_sr       <= '0;
      r_gcnt     <= '0;
      r_bcnt     <= '0;
      r_data_out <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      r_restart  <= 1'b0;
      r_pbv_prev <= 1'b0;
    end else begin
      r_sr       <= w_sr_nxt;
      r_gcnt     <= w_gcnt_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_data_out <= w_data_out_nxt;
      r_done     <= w_done_nxt;
      r_underrun <= w_underrun_nxt;
      r_restart  <= w_restart_nxt;
      if (w_wr) r_pbv_prev <= w_pbv_s;
    end
  end

  // Staging register. The frame start drains the old contents before the
  // load below re-fills it, so a word loaded on the same cycle is kept.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      r_staged     <= 1'b0;
      r_stage_data <= '0;
    end else begin
      if (w_fs) r_staged <= 1'b0;
      if (w_load) begin
        r_staged     <= 1'b1;
        r_stage_data <= tx_data;
      end
    end
  end

  assign tx_ready = ~r_staged;
  assign DATA_OUT = r_data_out;
  assign busy     = (r_state == ST_GUARD) || (r_state == ST_SHIFT);
  assign done     = r_done;
  assign underrun = r_underrun;
  assign restart  = r_restart;

endmodule

// File: tb/tb_lvda_serial_word_tx.sv
// tb/tb_lvda_serial_word_tx.sv - self-checking bench for lvda_serial_word_tx
module tb_lvda_serial_word_tx;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST;
  logic        WDA;
  logic        PBV;
  logic [25:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        DATA_OUT;
  logic        busy;
  logic        done;
  logic        underrun;
  logic        restart;

  lvda_serial_word_tx dut (
    .SIM_CLK  (SIM_CLK),
    .SIM_RST  (SIM_RST),
    .WDA      (WDA),
    .PBV      (PBV),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .DATA_OUT (DATA_OUT),
    .busy     (busy),
    .done     (done),
    .underrun (underrun),
    .restart  (restart)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse counters, sampled away from the active edge
  int cnt_done = 0, cnt_under = 0, cnt_restart = 0;
  always @(negedge SIM_CLK) begin
    if (done)     cnt_done++;
    if (underrun) cnt_under++;
    if (restart)  cnt_restart++;
  end

  // Reference model: link-level view (PBV rise on a strobe starts a frame,
  // edge count since the start decides what is on the wire).
  bit          m_pbv_prev, m_staged, m_active;
  logic [25:0] m_stage_word, m_word, m_rx;
  int          m_e;
  bit          exp_done, exp_under, exp_restart;
  logic [25:0] rx_log[$];

  function automatic logic [31:0] rx_back(input int back);
    if (rx_log.size() > back) return {6'd0, rx_log[rx_log.size()-1-back]};
    return 32'hxxxxxxxx;
  endfunction

  // LVDC capture shifter model, evaluated on each WDA rise
  task automatic model_edge();
    bit   fs;
    logic dv;
    dv = DATA_OUT;
    fs = PBV && !m_pbv_prev;
    m_pbv_prev = PBV;
    exp_done = 0; exp_under = 0; exp_restart = 0;
    if (fs) begin
      exp_restart = m_active;
      if (m_staged) m_word = m_stage_word;
      else begin m_word = '0; exp_under = 1; end
      m_staged = 0; m_active = 1; m_e = 0; m_rx = '0;
    end else if (m_active) begin
      m_e++;
      if (m_e >= 2 && m_e <= 27) m_rx = {m_rx[24:0], dv};
      if (m_e == 27) begin
        chk("rx_word", {6'd0, m_rx}, {6'd0, m_word});
        rx_log.push_back(m_rx);
      end
      if (m_e == 28) begin exp_done = 1; m_active = 0; end
    end
  endtask

  // One WDA period (16 clocks, 8 high / 8 low) with optional load / reset
  task automatic wda_cycle(input int load_at, input logic [25:0] load_word, input int rst_at);
    int   d0, u0, r0;
    logic exp_dv;
    model_edge();
    d0 = cnt_done; u0 = cnt_under; r0 = cnt_restart;
    WDA = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) WDA = 1'b0;
      if (load_at >= 0 && i == load_at) begin
        chk("tx_ready_pre_load", {31'd0, tx_ready}, {31'd0, !m_staged});
        tx_valid = 1'b1;
        tx_data  = load_word;
        if (!m_staged) begin m_staged = 1; m_stage_word = load_word; end
      end
      if (load_at >= 0 && i == load_at + 1) tx_valid = 1'b0;
      if (rst_at >= 0 && i == rst_at) SIM_RST = 1'b1;
      if (rst_at >= 0 && i == rst_at + 1) begin
        SIM_RST = 1'b0;
        chk("rst_data_out", {31'd0, DATA_OUT}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        m_staged = 0; m_active = 0; m_pbv_prev = 0;
      end
      if (i == 6) begin
        exp_dv = 1'b0;
        if (m_active && m_e >= 1 && m_e <= 26) exp_dv = m_word[26-m_e];
        chk("data_out", {31'd0, DATA_OUT}, {31'd0, exp_dv});
        chk("busy", {31'd0, busy}, {31'd0, (m_active && m_e <= 26)});
        chk("tx_ready", {31'd0, tx_ready}, {31'd0, !m_staged});
      end
      @(negedge SIM_CLK);
    end
    chk("done_pulses", cnt_done - d0, {31'd0, exp_done});
    chk("underrun_pulses", cnt_under - u0, {31'd0, exp_under});
    chk("restart_pulses", cnt_restart - r0, {31'd0, exp_restart});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) wda_cycle(-1, '0, -1);
  endtask

  initial begin
    logic [25:0] w;
    int          c0, n0;
    SIM_RST = 1'b1; WDA = 1'b0; PBV = 1'b0; tx_valid = 1'b0; tx_data = '0;
    m_pbv_prev = 0; m_staged = 0; m_active = 0; m_e = 0;
    m_word = '0; m_rx = '0; m_stage_word = '0;
    repeat (4) @(negedge SIM_CLK);
    SIM_RST = 1'b0;
    chk("reset_data_out", {31'd0, DATA_OUT}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_underrun", {31'd0, underrun}, 32'd0);
    chk("reset_restart", {31'd0, restart}, 32'd0);
    chk("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    idle(2);

    // T1 basic
    wda_cycle(10, 26'h2AAAAAA, -1);
    PBV = 1'b1; idle(30);
    PBV = 1'b0; idle(1);
    chk("t1_word", rx_back(0), 32'h2AAAAAA);

    // T2 back-to-back, second word staged while the first is shifting
    wda_cycle(10, 26'h3FFFFFF, -1);
    PBV = 1'b1; idle(5);
    wda_cycle(10, 26'h0000001, -1);
    idle(24);
    PBV = 1'b0; idle(1);
    PBV = 1'b1; idle(30);
    PBV = 1'b0; idle(1);
    chk("t2_first", rx_back(1), 32'h3FFFFFF);
    chk("t2_second", rx_back(0), 32'h0000001);

    // T3 underrun
    PBV = 1'b1; idle(30);
    PBV = 1'b0; idle(1);
    chk("t3_word", rx_back(0), 32'h0);

    // T4 restart at wr 10
    wda_cycle(10, 26'h1234567, -1);
    n0 = rx_log.size(); c0 = cnt_done;
    PBV = 1'b1; idle(9);
    PBV = 1'b0; wda_cycle(10, 26'h0ABCDEF, -1);
    PBV = 1'b1; idle(30);
    PBV = 1'b0; idle(1);
    chk("t4_word", rx_back(0), 32'h0ABCDEF);
    chk("t4_frames", rx_log.size() - n0, 32'd1);
    chk("t4_done_count", cnt_done - c0, 32'd1);

    // T5 reset at wr 15
    w = 26'($urandom);
    wda_cycle(10, w, -1);
    c0 = cnt_done;
    PBV = 1'b1; idle(15);
    PBV = 1'b0; wda_cycle(-1, '0, 12);
    idle(2);
    chk("t5_no_done", cnt_done - c0, 32'd0);
    wda_cycle(10, 26'h155, -1);
    PBV = 1'b1; idle(30);
    PBV = 1'b0; idle(1);
    chk("t5_word", rx_back(0), 32'h155);

    // T6 load coincident with fs, then PBV held high
    w = 26'($urandom);
    c0 = cnt_done;
    PBV = 1'b1; wda_cycle(2, w, -1);
    idle(90);
    chk("t6_one_frame", cnt_done - c0, 32'd1);
    chk("t6_underrun_word", rx_back(0), 32'h0);
    PBV = 1'b0; idle(1);
    PBV = 1'b1; idle(30);
    PBV = 1'b0; idle(1);
    chk("t6_staged_word", rx_back(0), {6'd0, w});

    // Randomised frames
    for (int k = 0; k < 6; k++) begin
      w = 26'($urandom);
      wda_cycle(int'($urandom_range(8, 14)), w, -1);
      idle(int'($urandom_range(0, 2)));
      PBV = 1'b1; idle(29 + int'($urandom_range(0, 2)));
      PBV = 1'b0; idle(1);
      chk("rand_word", rx_back(0), {6'd0, w});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
